// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate cache with one word per line in front of a 32x8 sync RAM.
// All RAM traffic (victim write-back, line fill) is sequenced here; hit/miss counters saturate at 255.
module cache_controller #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int INDEX_BITS = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  cpu_req,
  input  logic                  cpu_wren,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_data,
  output logic [DATA_WIDTH-1:0] cpu_q,
  output logic                  done,
  output logic                  hit,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [7:0]            hit_count,
  output logic [7:0]            miss_count
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS;

  typedef enum logic [2:0] {S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOC, S_WAIT} state_t;

  typedef struct packed {
    logic                  wren;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  state_t state, next;
  req_t   req;

  logic [LINES-1:0][DATA_WIDTH-1:0] lines;
  logic [LINES-1:0][TAG_BITS-1:0]   tags;
  logic [LINES-1:0]                 valid, dirty;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  lookup_hit;

  assign idx        = req.addr[INDEX_BITS-1:0];
  assign req_tag    = req.addr[ADDR_WIDTH-1:INDEX_BITS];
  assign lookup_hit = valid[idx] && (tags[idx] == req_tag);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next;
  end

  always_comb begin
    next        = state;
    ram_address = req.addr;
    ram_data    = lines[idx];
    ram_wren    = 1'b0;
    case (state)
      S_IDLE:    if (cpu_req) next = S_COMPARE;
      S_COMPARE: begin
        if (lookup_hit)                   next = S_IDLE;
        else if (valid[idx] && dirty[idx]) next = S_WRITEBACK;
        else                              next = S_ALLOC;
      end
      S_WRITEBACK: begin
        // victim address is rebuilt from the stored tag, not the request
        ram_address = {tags[idx], idx};
        ram_wren    = 1'b1;
        next        = S_ALLOC;
      end
      S_ALLOC:   next = S_WAIT;
      S_WAIT:    next = S_IDLE;
      default:   next = S_IDLE;
    endcase
  end

  // Control state: reset aborts any in-flight access and drops dirty lines.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      req        <= '0;
      valid      <= '0;
      dirty      <= '0;
      cpu_q      <= '0;
      done       <= 1'b0;
      hit        <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      done <= 1'b0;
      hit  <= 1'b0;
      case (state)
        S_IDLE: if (cpu_req) req <= '{wren: cpu_wren, addr: cpu_address, data: cpu_data};
        S_COMPARE: begin
          if (lookup_hit) begin
            done <= 1'b1;
            hit  <= 1'b1;
            if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
            if (req.wren) dirty[idx] <= 1'b1;
            else          cpu_q      <= lines[idx];
          end else if (miss_count != 8'hFF) begin
            miss_count <= miss_count + 8'd1;
          end
        end
        S_WAIT: begin
          valid[idx] <= 1'b1;
          dirty[idx] <= req.wren;
          if (!req.wren) cpu_q <= ram_q;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Line payload and tags need no reset; valid bits gate their use.
  always_ff @(posedge clock) begin
    if (state == S_COMPARE && lookup_hit && req.wren) lines[idx] <= req.data;
    if (state == S_WAIT) begin
      tags[idx]  <= req_tag;
      lines[idx] <= req.wren ? req.data : ram_q;
    end
  end
endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench: driver predicts each access from a flat-memory + residency model, monitor checks on done/ram_wren.
module tb_cache_controller;
  logic       clock = 1'b0;
  logic       resetn;
  logic       cpu_req, cpu_wren;
  logic [4:0] cpu_address;
  logic [7:0] cpu_data, cpu_q;
  logic       done, hit, busy;
  logic [4:0] ram_address;
  logic [7:0] ram_data, ram_q;
  logic       ram_wren;
  logic [7:0] hit_count, miss_count;

  cache_controller dut (
    .clock(clock), .resetn(resetn), .cpu_req(cpu_req), .cpu_wren(cpu_wren),
    .cpu_address(cpu_address), .cpu_data(cpu_data), .cpu_q(cpu_q), .done(done),
    .hit(hit), .busy(busy), .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_q(ram_q), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    if (i == 1) return 8'h03;
    if (i == 9) return 8'h5C;
    return 8'(i * 37 + 11);
  endfunction

  // 32x8 synchronous single-port RAM
  logic [7:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clock);
      if (ram_wren) mem[ram_address] <= ram_data;
      ram_q <= mem[ram_address];
    end
  end

  typedef struct {
    logic       hit;
    logic [7:0] q;
    int         lat;
    int         acc;
    int         hc;
    int         mc;
  } exp_t;
  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
  } wb_t;

  exp_t exp_q[$];
  wb_t  wb_q[$];

  // Reference model: what the CPU should see per address, plus which tag is resident per index.
  logic [7:0] truth [32];
  logic [7:0] ram_exp [32];
  logic [1:0] mtag [8];
  bit         mvalid [8];
  bit         mdirty [8];
  int         hc, mc;
  logic [7:0] last_q;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_msg(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin mvalid[i] = 0; mdirty[i] = 0; mtag[i] = '0; end
    for (int i = 0; i < 32; i++) truth[i] = ram_exp[i];
    hc = 0; mc = 0; last_q = '0;
  endtask

  task automatic reset_checks();
    chk("rst_done", done, 0);
    chk("rst_hit", hit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cpu_q", cpu_q, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    chk("rst_ram_wren", ram_wren, 0);
  endtask

  function automatic int predict_lat(input logic [4:0] a);
    if (mvalid[a[2:0]] && mtag[a[2:0]] == a[4:3]) return 1;
    return (mvalid[a[2:0]] && mdirty[a[2:0]]) ? 4 : 3;
  endfunction

  // Called at #1 after an edge with the DUT idle. Returns in the done cycle unless aborted.
  task automatic issue(input logic w, input logic [4:0] a, input logic [7:0] d, input bit abort);
    exp_t       e;
    logic [2:0] ix = a[2:0];
    logic [1:0] tg = a[4:3];
    logic [4:0] va;
    bit         h;
    cpu_req = 1'b1; cpu_wren = w; cpu_address = a; cpu_data = d;
    @(posedge clock); #1;
    cpu_req = 1'b0;
    h     = mvalid[ix] && mtag[ix] == tg;
    e.lat = predict_lat(a);
    if (h) begin
      if (hc < 255) hc++;
    end else begin
      if (mc < 255) mc++;
      if (mvalid[ix] && mdirty[ix]) begin
        va = {mtag[ix], ix};
        wb_q.push_back('{a: va, d: truth[va]});
        ram_exp[va] = truth[va];
      end
    end
    mdirty[ix] = h ? (mdirty[ix] | w) : w;
    mvalid[ix] = 1;
    mtag[ix]   = tg;
    if (w) truth[a] = d;
    else   last_q = truth[a];
    e.hit = h; e.q = last_q; e.acc = cyc; e.hc = hc; e.mc = mc;
    if (abort) begin
      repeat (e.lat - 1) @(posedge clock);
      #1;
      resetn = 1'b0;
      @(posedge clock); #1;
      reset_checks();
      resetn = 1'b1;
      model_reset();
    end else begin
      exp_q.push_back(e);
      // Stray requests while busy must be ignored.
      for (int n = 0; n < 20 && busy; n++) begin
        cpu_req     = 1'($urandom_range(0, 1));
        cpu_wren    = 1'($urandom_range(0, 1));
        cpu_address = 5'($urandom_range(0, 31));
        cpu_data    = 8'($urandom);
        @(posedge clock); #1;
      end
      cpu_req = 1'b0;
      if (busy) fail_msg("busy_timeout");
    end
  endtask

  exp_t mon_e;
  wb_t  mon_w;
  logic prev_wren = 1'b0;
  always @(negedge clock) begin
    if (resetn) begin
      if (done) begin
        if (exp_q.size() == 0) fail_msg("unexpected_done");
        else begin
          mon_e = exp_q.pop_front();
          chk("hit", hit, mon_e.hit);
          chk("cpu_q", cpu_q, mon_e.q);
          chk("latency", cyc - mon_e.acc, mon_e.lat);
          chk("hit_count", hit_count, mon_e.hc);
          chk("miss_count", miss_count, mon_e.mc);
        end
      end
      if (ram_wren) begin
        chk("wren_one_cycle", prev_wren, 0);
        if (wb_q.size() == 0) fail_msg("unexpected_writeback");
        else begin
          mon_w = wb_q.pop_front();
          chk("wb_addr", ram_address, mon_w.a);
          chk("wb_data", ram_data, mon_w.d);
        end
      end
      prev_wren = ram_wren;
    end else begin
      prev_wren = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [4:0] a;
  int         mism;
  initial begin
    resetn = 1'b0; cpu_req = 1'b0; cpu_wren = 1'b0; cpu_address = '0; cpu_data = '0;
    for (int i = 0; i < 32; i++) ram_exp[i] = init_val(i);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_checks();
    resetn = 1'b1;

    // Directed: clean miss, hit, write-allocate, dirty eviction
    issue(1'b0, 5'h01, 8'h00, 0);
    issue(1'b0, 5'h01, 8'h00, 0);
    chk("t1_hit_count", hit_count, 1);
    chk("t1_miss_count", miss_count, 1);
    issue(1'b1, 5'h09, 8'hAA, 0);
    chk("t2_ram9_unchanged", mem[9], 8'h5C);
    issue(1'b0, 5'h09, 8'h00, 0);
    chk("t2_read_back", cpu_q, 8'hAA);
    issue(1'b0, 5'h01, 8'h00, 0);
    chk("t3_cpu_q", cpu_q, 8'h03);
    chk("t3_ram9_written", mem[9], 8'hAA);
    issue(1'b0, 5'h1F, 8'h00, 0);

    // Random traffic with occasional idle gaps
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 7) == 0) begin @(posedge clock); #1; end
      issue(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom), 0);
    end

    // Reset while the fill is in WAIT; the same read must miss afterwards
    a = mvalid[3] ? {mtag[3] + 2'd1, 3'd3} : 5'h03;
    issue(1'b0, a, 8'h00, 1);
    issue(1'b0, a, 8'h00, 0);

    // Hit counter saturation
    for (int i = 0; i < 300; i++) issue(1'b0, a, 8'h00, 0);
    chk("sat_hit_count", hit_count, 255);
    chk("sat_miss_count", miss_count, 1);

    repeat (3) @(posedge clock);
    #1;
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("wb_queue_drained", wb_q.size(), 0);
    mism = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== ram_exp[i]) mism++;
    chk("ram_contents_mismatches", mism, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Direct-mapped, write-back, write-allocate cache controller in front of the 32x8 single-port synchronous RAM (`Ram`: address, clock, data, wren, q).
- Sits between a CPU-side request port and the RAM instance, and sequences all RAM traffic: line fills on a miss, write-back of dirty victims.
- Holds one 8-bit word per line, plus a tag, valid bit and dirty bit per line, all in internal registers.
- Keeps saturating hit/miss counters for the memory-hierarchy lab measurements.

Parameters:
- ADDR_WIDTH, 5, CPU/RAM word address width.
- DATA_WIDTH, 8, word width.
- INDEX_BITS, 3, line index width. Lines = 2^INDEX_BITS = 8. TAG = ADDR_WIDTH-INDEX_BITS = 2 bits.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_wren  in  1  1=write, 0=read.
- cpu_address  in  ADDR_WIDTH  word address {tag,index}.
- cpu_data  in  DATA_WIDTH  write data.
- cpu_q  out  DATA_WIDTH  read data; valid while done=1, held until the next done.
- done  out  1  one-cycle completion pulse.
- hit  out  1  qualifies done: 1=hit, 0=miss.
- busy  out  1  high whenever state != IDLE.
- ram_address  out  ADDR_WIDTH  to Ram address.
- ram_data  out  DATA_WIDTH  to Ram data.
- ram_wren  out  1  to Ram wren.
- ram_q  in  DATA_WIDTH  from Ram q; valid one cycle after the address is clocked.
- hit_count  out  8  saturating hit counter.
- miss_count  out  8  saturating miss counter.

Behaviour:

Reset (resetn=0 at an edge):
- state=IDLE; all valid and dirty bits cleared.
- cpu_q=0, done=0, hit=0, counters=0, ram_wren=0.
- Reset mid-operation aborts immediately. Dirty data is discarded with no write-back.

Request acceptance:
- In IDLE, cpu_req=1 latches cpu_wren, cpu_address and cpu_data, then moves to COMPARE.
- cpu_req in any other state is ignored; the requester waits for busy=0.

States:
- IDLE: ram_wren=0; ram_address=latched address.
- COMPARE: hit = valid[idx] && tag[idx]==req_tag.
  - Hit read: cpu_q<=line[idx].
  - Hit write: line[idx]<=req_data, dirty[idx]<=1.
  - On any hit: done<=1, hit<=1, hit_count++, then go to IDLE.
  - Miss: miss_count++. If valid&&dirty go to WRITEBACK, else go to ALLOC.
- WRITEBACK: ram_address={tag[idx],idx}, ram_data=line[idx], ram_wren=1 for exactly this one cycle, then ALLOC.
- ALLOC: ram_address=req address, ram_wren=0, then WAIT.
- WAIT: ram_q is valid.
  - Set tag[idx]<=req_tag and valid<=1.
  - Read: line<=ram_q, cpu_q<=ram_q, dirty<=0.
  - Write: line<=req_data, dirty<=1; cpu_q unchanged.
  - done<=1, hit<=0, then go to IDLE.

Outputs and timing:
- ram_* are a decode of state plus latched registers. ram_wren is high only in WRITEBACK.
- done and hit are registered and high for one cycle, the first cycle back in IDLE. A new request may be accepted in that same cycle.

Latency, counted from the acceptance edge to the edge after which done is high:
- Hit: 1 edge. done is visible in the 2nd cycle after the request cycle.
- Clean miss: 3 edges.
- Dirty miss: 4 edges.

Counters:
- Each counter saturates at 255 and never wraps.
- Each access increments exactly one counter, once.

Boundaries:
- Index wrap: same index with a different tag evicts.
- Address 31 maps to index 7, tag 3.
- A write miss to an invalid line performs a fill read before the merge; the RAM is not written until eviction.

Test Plan:
1. After reset, read addr 5'h01 with RAM[1]=8'h03 -> clean miss: done after 3 edges, hit=0, cpu_q=8'h03, miss_count=1; repeat the read -> done after 1 edge, hit=1, hit_count=1.
2. Write 8'hAA to 5'h09 (idx1, tag1) -> write miss: fill, line dirty, RAM[9] unchanged; read 5'h09 -> hit, cpu_q=8'hAA.
3. Then read 5'h01 (idx1, tag0) -> dirty eviction: one-cycle ram_wren=1 with ram_address=5'h09 and ram_data=8'hAA, then fill from 1; done after 4 edges with cpu_q=8'h03; RAM[9]=8'hAA afterwards.
4. Assert cpu_req during busy -> ignored, no counter change; a back-to-back request in the done cycle -> accepted.
5. resetn=0 in WAIT of a miss -> no done pulse, valid bits cleared, ram_wren=0; the next read of the same address misses again.
6. 300 repeated hits -> hit_count holds at 255; miss_count unchanged.
